// File: rtl/fa_pkg.sv
// Shared types and helpers for the bit-serial adder.
package fa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width: clog2 of the operand width, never less than one bit.
  function automatic int cnt_width(input int w);
    if (w <= 1) return 1;
    return $clog2(w);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational one-bit full adder; the only arithmetic in the datapath.
module fa_cell (
  input  logic ain,
  input  logic bin,
  input  logic cin,
  output logic sout,
  output logic cout
);

  // Classic sum/majority equations.
  always_comb begin
    sout = ain ^ bin ^ cin;
    cout = (ain & bin) | (ain & cin) | (bin & cin);
  end

endmodule

// File: rtl/serial_fa_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, one bit per clock.
//
//   state | meaning
//   IDLE  | waiting for start, results held
//   RUN   | processing one operand bit per edge
//   DONE  | one-cycle result-valid pulse, may restart back-to-back
module serial_fa_adder
  import fa_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sout,
  output logic             cout,
  output logic             ovf
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic             load, shift, last;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt;
  logic             carry;
  logic [CW-1:0]    bitcnt;
  logic             s_bit, c_bit;

  fa_cell u_cell (
    .ain  (a_sh[0]),
    .bin  (b_sh[0]),
    .cin  (carry),
    .sout (s_bit),
    .cout (c_bit)
  );

  // Sum bits enter the accumulator from the MSB side so the LSB ends up at bit 0.
  generate
    if (WIDTH == 1) begin : g_acc1
      assign acc_nxt = s_bit;
    end else begin : g_accn
      assign acc_nxt = {s_bit, acc[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        shift = 1'b1;
        if (bitcnt == LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, serial shifting and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      bitcnt <= '0;
      sout   <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (load) begin
      // Subtract as A + ~B + 1; cin becomes a borrow, hence the inversion.
      a_sh   <= ain;
      b_sh   <= bin ^ {WIDTH{sub}};
      carry  <= cin ^ sub;
      bitcnt <= '0;
    end else if (shift) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      acc    <= acc_nxt;
      carry  <= c_bit;
      bitcnt <= bitcnt + CW'(1);
      if (last) begin
        sout <= acc_nxt;
        cout <= c_bit;
        ovf  <= carry ^ c_bit;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_fa_adder.sv
// Directed self-checking bench for serial_fa_adder (WIDTH=8 and WIDTH=1).
module tb_serial_fa_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0] ain8 = '0, bin8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sout8;

  logic       start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
  logic [0:0] ain1 = '0, bin1 = '0;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] sout1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  serial_fa_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .ain(ain8), .bin(bin8),
    .cin(cin8), .busy(busy8), .done(done8), .sout(sout8), .cout(cout8), .ovf(ovf8)
  );

  serial_fa_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .ain(ain1), .bin(bin1),
    .cin(cin1), .busy(busy1), .done(done1), .sout(sout1), .cout(cout1), .ovf(ovf1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one WIDTH=8 operation and wait (bounded) for done.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                     output int lat, output int nbusy);
    ain8 = a; bin8 = b; cin8 = c; sub8 = s; start8 = 1'b1;
    lat = 0; nbusy = 0;
    tick(); lat = 1; start8 = 1'b0;
    while (!done8 && lat < 40) begin
      if (busy8) nbusy++;
      tick(); lat++;
    end
  endtask

  int lat, nbusy, ndone;

  initial begin
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_sout", sout8, 8'h00);
    chk("rst_cout", cout8, 0);
    chk("rst_ovf",  ovf8, 0);

    // Basic add with latency/busy accounting.
    op8(8'h0F, 8'h01, 0, 0, lat, nbusy);
    chk("add_lat",  lat, 9);
    chk("add_busy", nbusy, 8);
    chk("add_done_busy_low", busy8, 0);
    chk("add_sout", sout8, 8'h10);
    chk("add_cout", cout8, 0);
    chk("add_ovf",  ovf8, 0);
    tick();
    chk("done_pulse_one_cycle", done8, 0);
    chk("hold_sout_idle", sout8, 8'h10);

    op8(8'hFF, 8'h01, 0, 0, lat, nbusy);
    chk("ff1_sout", sout8, 8'h00);
    chk("ff1_cout", cout8, 1);
    chk("ff1_ovf",  ovf8, 0);
    tick();

    op8(8'h7F, 8'h01, 0, 0, lat, nbusy);
    chk("7f1_sout", sout8, 8'h80);
    chk("7f1_cout", cout8, 0);
    chk("7f1_ovf",  ovf8, 1);
    tick();

    op8(8'h0F, 8'h01, 1, 0, lat, nbusy);
    chk("addcin_sout", sout8, 8'h11);
    tick();

    op8(8'h05, 8'h07, 0, 1, lat, nbusy);
    chk("sub57_sout", sout8, 8'hFE);
    chk("sub57_cout", cout8, 0);
    chk("sub57_ovf",  ovf8, 0);
    tick();

    op8(8'h07, 8'h05, 0, 1, lat, nbusy);
    chk("sub75_sout", sout8, 8'h02);
    chk("sub75_cout", cout8, 1);
    tick();

    op8(8'h80, 8'h01, 0, 1, lat, nbusy);
    chk("sub801_sout", sout8, 8'h7F);
    chk("sub801_ovf",  ovf8, 1);
    tick();

    op8(8'h07, 8'h05, 1, 1, lat, nbusy);
    chk("subbin_sout", sout8, 8'h01);
    chk("subbin_cout", cout8, 1);
    tick();

    // Start pulsed mid-RUN must be ignored.
    ain8 = 8'h0F; bin8 = 8'h01; cin8 = 0; sub8 = 0; start8 = 1'b1;
    tick(); start8 = 1'b0;
    tick(); tick();
    chk("run_busy_mid", busy8, 1);
    chk("run_sout_held", sout8, 8'h01);
    ain8 = 8'hFF; bin8 = 8'hFF; start8 = 1'b1;
    tick(); start8 = 1'b0;
    lat = 4;
    while (!done8 && lat < 40) begin tick(); lat++; end
    chk("ign_lat", lat, 9);
    chk("ign_sout", sout8, 8'h10);
    tick();
    chk("ign_no_rerun", busy8, 0);
    tick();

    // Back-to-back: start held through DONE.
    ain8 = 8'h12; bin8 = 8'h34; cin8 = 0; sub8 = 0; start8 = 1'b1;
    lat = 0;
    tick(); lat = 1;
    while (!done8 && lat < 40) begin tick(); lat++; end
    chk("b2b_lat1", lat, 9);
    chk("b2b_sout1", sout8, 8'h46);
    ain8 = 8'h10; bin8 = 8'h20; sub8 = 1;
    tick(); start8 = 1'b0; lat = 1;
    chk("b2b_busy", busy8, 1);
    while (!done8 && lat < 40) begin tick(); lat++; end
    chk("b2b_gap", lat, 9);
    chk("b2b_sout2", sout8, 8'hF0);
    chk("b2b_cout2", cout8, 0);
    chk("b2b_ovf2", ovf8, 0);
    tick();

    // Reset at bit 4 of 0xAA+0x55.
    ain8 = 8'hAA; bin8 = 8'h55; cin8 = 0; sub8 = 0; start8 = 1'b1;
    tick(); start8 = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("mrst_busy", busy8, 0);
    chk("mrst_sout", sout8, 8'h00);
    chk("mrst_cout", cout8, 0);
    chk("mrst_ovf",  ovf8, 0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done8) ndone++;
      tick();
    end
    chk("mrst_no_done", ndone, 0);

    // WIDTH=1 exhaustive full-adder table.
    for (int v = 0; v < 8; v++) begin
      logic [1:0] want;
      cin1 = v[2]; ain1 = v[1]; bin1 = v[0]; sub1 = 0;
      want = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      start1 = 1'b1;
      tick(); start1 = 1'b0; lat = 1;
      while (!done1 && lat < 20) begin tick(); lat++; end
      chk($sformatf("w1_lat_%0d", v), lat, 2);
      chk($sformatf("w1_sout_%0d", v), sout1, want[0]);
      chk($sformatf("w1_cout_%0d", v), cout1, want[1]);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
